// File: rtl/cmd_pkg.sv
// Shared types and constants for the command SIPO frame decoder.
// SIPO_CHECKSUM_EN adds the CHECK state used for the trailing checksum byte.
`timescale 1ns/1ps
package cmd_pkg;

    localparam logic [7:0] HDR_BYTE_DEFAULT = 8'hA5;

    localparam logic [1:0] DEST_MOTOR = 2'b00;
    localparam logic [1:0] DEST_SERVO = 2'b01;
    localparam logic [1:0] DEST_PISO  = 2'b10;

    typedef enum logic [2:0] {
        IDLE,
        HUNT,
        CMD,
        PAYLOAD,
`ifdef SIPO_CHECKSUM_EN
        CHECK,
`endif
        DONE
    } state_t;

    // The two top bits of the command byte select the destination; 2'b11 is unused.
    function automatic logic dest_ok(input logic [7:0] id);
        return id[7:6] != 2'b11;
    endfunction

endpackage

// File: rtl/sipo_shift.sv
// Payload byte shift register (LSB-first) with a beat counter.
// data_next is the register value including the beat being shifted in this cycle.
`timescale 1ns/1ps
module sipo_shift #(
    parameter int PAYLOAD_BYTES = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clear,
    input  logic                       shift,
    input  logic [7:0]                 din,
    output logic [PAYLOAD_BYTES*8-1:0] data_next,
    output logic                       last
);

    localparam int W  = PAYLOAD_BYTES * 8;
    localparam int CW = $clog2(PAYLOAD_BYTES + 1);

    logic [W-1:0]  data_q;
    logic [W-1:0]  shifted;
    logic [CW-1:0] count_q;

    // New bytes enter at the top so the first payload byte ends up in bits [7:0].
    generate
        if (PAYLOAD_BYTES == 1) begin : g_one
            assign shifted = din;
        end else begin : g_multi
            assign shifted = {din, data_q[W-1:8]};
        end
    endgenerate

    assign data_next = shift ? shifted : data_q;
    assign last      = (count_q == CW'(PAYLOAD_BYTES - 1));

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            data_q  <= '0;
            count_q <= '0;
        end else if (shift) begin
            data_q  <= shifted;
            count_q <= count_q + 1'b1;
        end
    end

endmodule

// File: rtl/cmd_sipo.sv
// Frame decoder: hunts for HDR_BYTE, latches a command byte and PAYLOAD_BYTES payload bytes.
// Define SIPO_CHECKSUM_EN to require a trailing XOR checksum byte per frame.
`timescale 1ns/1ps
module cmd_sipo
    import cmd_pkg::*;
#(
    parameter int         PAYLOAD_BYTES = 4,
    parameter logic [7:0] HDR_BYTE      = HDR_BYTE_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sipo_en,
    input  logic        rd_en,
    input  logic        empty,
    input  logic [7:0]  din,
    output logic        sipo_done,
    output logic        frame_valid,
    output logic        frame_err,
    output logic [7:0]  cmd_id,
    output logic [31:0] cmd_data,
    output logic [1:0]  cmd_dest
);

    localparam int W = PAYLOAD_BYTES * 8;

    state_t       state_q, state_d;
    logic         beat_q;
    logic [7:0]   cmd_byte;
    logic         shift_en, clear, cmd_load, finish, last_beat, frame_bad;
    logic [W-1:0] data_next;
    logic [1:0]   dest_code;

    // The FIFO has no backpressure: a read is taken when rd_en && !empty, and
    // its byte is on din (a "beat") in the following cycle only.
    always_ff @(posedge clk) begin
        if (rst) beat_q <= 1'b0;
        else     beat_q <= rd_en && !empty;
    end

    sipo_shift #(.PAYLOAD_BYTES(PAYLOAD_BYTES)) u_shift (
        .clk       (clk),
        .rst       (rst),
        .clear     (clear),
        .shift     (shift_en),
        .din       (din),
        .data_next (data_next),
        .last      (last_beat)
    );

`ifdef SIPO_CHECKSUM_EN
    logic [7:0] chk_q;

    always_ff @(posedge clk) begin
        if (rst)           chk_q <= '0;
        else if (cmd_load) chk_q <= din;
        else if (shift_en) chk_q <= chk_q ^ din;
    end

    assign frame_bad = !dest_ok(cmd_byte) || (din != chk_q);
`else
    assign frame_bad = !dest_ok(cmd_byte);
`endif

    always_comb begin
        case (cmd_byte[7:6])
            2'b00:   dest_code = DEST_MOTOR;
            2'b01:   dest_code = DEST_SERVO;
            default: dest_code = DEST_PISO;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        shift_en = 1'b0;
        clear    = 1'b0;
        cmd_load = 1'b0;
        finish   = 1'b0;
        if (!sipo_en) begin
            state_d = IDLE;
            clear   = 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = HUNT;
                    clear   = 1'b1;
                end
                // A beat landing in DONE is the first HUNT beat of the next frame.
                HUNT, DONE: begin
                    clear   = 1'b1;
                    state_d = HUNT;
                    if (beat_q && din == HDR_BYTE) state_d = CMD;
                end
                CMD: begin
                    if (beat_q) begin
                        cmd_load = 1'b1;
                        state_d  = PAYLOAD;
                    end
                end
                PAYLOAD: begin
                    if (beat_q) begin
                        shift_en = 1'b1;
                        if (last_beat) begin
`ifdef SIPO_CHECKSUM_EN
                            state_d = CHECK;
`else
                            finish  = 1'b1;
                            state_d = DONE;
`endif
                        end
                    end
                end
`ifdef SIPO_CHECKSUM_EN
                CHECK: begin
                    if (beat_q) begin
                        finish  = 1'b1;
                        state_d = DONE;
                    end
                end
`endif
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (rst)           cmd_byte <= '0;
        else if (cmd_load) cmd_byte <= din;
    end

    // Pulses and decoded fields are registered so they appear during DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            sipo_done   <= 1'b0;
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
            cmd_id      <= '0;
            cmd_data    <= '0;
            cmd_dest    <= '0;
        end else begin
            sipo_done   <= finish;
            frame_valid <= finish && !frame_bad;
            frame_err   <= finish && frame_bad;
            if (finish && !frame_bad) begin
                cmd_id   <= cmd_byte;
                cmd_data <= 32'(data_next);
                cmd_dest <= dest_code;
            end
        end
    end

endmodule

// File: tb/tb_cmd_sipo.sv
// Self-checking bench for cmd_sipo: stream-level frame model feeding an expected queue.
// Covers the default build and, when SIPO_CHECKSUM_EN is defined, the checksum byte.
`timescale 1ns/1ps
module tb_cmd_sipo;

    localparam int         P   = 4;
    localparam logic [7:0] HDR = 8'hA5;
`ifdef SIPO_CHECKSUM_EN
    localparam int CHK_LEN = 1;
`else
    localparam int CHK_LEN = 0;
`endif
    localparam int FRAME_LEN = 2 + P + CHK_LEN;
    // expected entry: {done cycle[74:43], err[42], id[41:34], data[33:2], dest[1:0]}
    localparam int EW = 75;

    logic        clk, rst, sipo_en, rd_en, empty;
    logic [7:0]  din;
    logic        sipo_done, frame_valid, frame_err;
    logic [7:0]  cmd_id;
    logic [31:0] cmd_data;
    logic [1:0]  cmd_dest;

    cmd_sipo #(.PAYLOAD_BYTES(P), .HDR_BYTE(HDR)) dut (
        .clk         (clk),
        .rst         (rst),
        .sipo_en     (sipo_en),
        .rd_en       (rd_en),
        .empty       (empty),
        .din         (din),
        .sipo_done   (sipo_done),
        .frame_valid (frame_valid),
        .frame_err   (frame_err),
        .cmd_id      (cmd_id),
        .cmd_data    (cmd_data),
        .cmd_dest    (cmd_dest)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard state ----------------
    int checks = 0;
    int errors = 0;
    int n_done = 0, n_valid = 0, n_err = 0, n_exp = 0;

    logic [7:0]    mdl_id   = '0;
    logic [31:0]   mdl_data = '0;
    logic [1:0]    mdl_dest = '0;
    logic [EW-1:0] exp_q[$];
    logic [7:0]    mdl_buf[$];

    typedef struct {
        logic [7:0] b;
        int         gap;
    } tx_t;
    tx_t tx_q[$];

    // Stream-level reference: a frame starts at HDR, then has a fixed length.
    function automatic void model_feed(input logic [7:0] b, input int acc_cyc);
        logic [7:0]  id, x;
        logic [31:0] d;
        logic        bad;
        if (mdl_buf.size() == 0 && b != HDR) return;
        mdl_buf.push_back(b);
        if (mdl_buf.size() == FRAME_LEN) begin
            id = mdl_buf[1];
            d  = '0;
            x  = id;
            for (int i = 0; i < P; i++) begin
                d[8*i +: 8] = mdl_buf[2+i];
                x = x ^ mdl_buf[2+i];
            end
            bad = (id[7:6] == 2'b11);
`ifdef SIPO_CHECKSUM_EN
            bad = bad || (mdl_buf[2+P] != x);
`endif
            exp_q.push_back({32'(acc_cyc + 2), bad, id, d, id[7:6]});
            n_exp++;
            mdl_buf.delete();
        end
    endfunction

    always @(negedge clk) begin
        logic [EW-1:0] e;
        if (!rst) begin
            if (frame_valid) n_valid++;
            if (frame_err)   n_err++;
            if (sipo_done) begin
                n_done++;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_done: sipo_done=1 at cycle %0d, none expected", cyc);
                end else begin
                    e = exp_q.pop_front();
                    if (32'(cyc) !== e[74:43]) begin
                        errors++;
                        $display("FAIL done_latency: got cycle %0d, expected %0d", cyc, e[74:43]);
                    end
                    checks++;
                    if (frame_valid !== !e[42] || frame_err !== e[42]) begin
                        errors++;
                        $display("FAIL frame_pulse: valid=%b err=%b, expected valid=%b err=%b",
                                 frame_valid, frame_err, !e[42], e[42]);
                    end
                    if (!e[42]) begin
                        mdl_id   = e[41:34];
                        mdl_data = e[33:2];
                        mdl_dest = e[1:0];
                    end
                end
            end else if (frame_valid || frame_err) begin
                checks++;
                errors++;
                $display("FAIL stray_pulse: valid=%b err=%b without sipo_done at cycle %0d",
                         frame_valid, frame_err, cyc);
            end
            checks++;
            if ({cmd_id, cmd_data, cmd_dest} !== {mdl_id, mdl_data, mdl_dest}) begin
                errors++;
                $display("FAIL outputs: id=%h data=%h dest=%b, expected id=%h data=%h dest=%b (cycle %0d)",
                         cmd_id, cmd_data, cmd_dest, mdl_id, mdl_data, mdl_dest, cyc);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic push_byte(input logic [7:0] b, input int gap);
        tx_t t;
        t.b   = b;
        t.gap = gap;
        tx_q.push_back(t);
    endtask

    task automatic push_frame(input logic [7:0] id, input logic [31:0] data, input int gap,
                              input bit use_ovr, input logic [7:0] ovr);
        logic [7:0] x;
        x = id;
        push_byte(HDR, gap);
        push_byte(id, gap);
        for (int i = 0; i < P; i++) begin
            push_byte(data[8*i +: 8], gap);
            x = x ^ data[8*i +: 8];
        end
`ifdef SIPO_CHECKSUM_EN
        push_byte(use_ovr ? ovr : x, gap);
`else
        if (use_ovr && ovr == x) x = ovr;
`endif
    endtask

    // Gap cycles present no accepted read (empty=1 or rd_en=0); din carries junk then.
    task automatic run_stream();
        tx_t        t;
        logic [7:0] pend;
        bit         pend_v;
        pend   = '0;
        pend_v = 1'b0;
        while (tx_q.size() > 0) begin
            t = tx_q.pop_front();
            for (int g = 0; g < t.gap; g++) begin
                @(negedge clk);
                din    = pend_v ? pend : 8'($urandom);
                pend_v = 1'b0;
                if ($urandom_range(0, 1) == 1) begin
                    rd_en = 1'b1;
                    empty = 1'b1;
                end else begin
                    rd_en = 1'b0;
                    empty = 1'($urandom);
                end
            end
            @(negedge clk);
            din    = pend_v ? pend : 8'($urandom);
            rd_en  = 1'b1;
            empty  = 1'b0;
            pend   = t.b;
            pend_v = 1'b1;
            model_feed(t.b, cyc);
        end
        @(negedge clk);
        din   = pend_v ? pend : 8'($urandom);
        rd_en = 1'b0;
        empty = 1'b1;
        @(negedge clk);
        din = 8'($urandom);
    endtask

    task automatic wait_drain(input int limit);
        int n;
        n = 0;
        while (exp_q.size() > 0 && n < limit) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout: %0d frames still expected after %0d cycles", exp_q.size(), limit);
            exp_q.delete();
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst     = 1'b1;
        sipo_en = 1'b1;
        rd_en   = 1'b1;
        empty   = 1'b0;
        din     = HDR;
        repeat (4) @(negedge clk);
        checks++;
        if ({sipo_done, frame_valid, frame_err} !== 3'b000) begin
            errors++;
            $display("FAIL reset_pulses: got %b, expected 000", {sipo_done, frame_valid, frame_err});
        end
        checks++;
        if ({cmd_id, cmd_data, cmd_dest} !== 42'd0) begin
            errors++;
            $display("FAIL reset_fields: id=%h data=%h dest=%b, expected all zero", cmd_id, cmd_data, cmd_dest);
        end
        rd_en = 1'b0;
        empty = 1'b1;
        rst   = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_basic();
        int v0;
        v0 = n_valid;
        push_frame(8'h41, 32'h44332211, 0, 1'b0, 8'h00);
        run_stream();
        wait_drain(50);
        checks++;
        if (n_valid !== v0 + 1) begin
            errors++;
            $display("FAIL basic_valid: %0d valid pulses, expected %0d", n_valid - v0, 1);
        end
        checks++;
        if (cmd_id !== 8'h41 || cmd_data !== 32'h44332211 || cmd_dest !== 2'b01) begin
            errors++;
            $display("FAIL basic_fields: id=%h data=%h dest=%b, expected 41 44332211 01", cmd_id, cmd_data, cmd_dest);
        end
    endtask

    task automatic test_hunt();
        push_byte(8'h00, 0);
        push_byte(8'h7F, 0);
        push_frame(8'h02, 32'h00000001, 0, 1'b0, 8'h00);
        run_stream();
        wait_drain(50);
        checks++;
        if (cmd_id !== 8'h02 || cmd_data !== 32'h00000001 || cmd_dest !== 2'b00) begin
            errors++;
            $display("FAIL hunt_fields: id=%h data=%h dest=%b, expected 02 00000001 00", cmd_id, cmd_data, cmd_dest);
        end
    endtask

    task automatic test_bad_dest();
        int v0, e0;
        v0 = n_valid;
        e0 = n_err;
        push_frame(8'hC0, $urandom, 0, 1'b0, 8'h00);
        run_stream();
        wait_drain(50);
        checks++;
        if (n_err !== e0 + 1 || n_valid !== v0) begin
            errors++;
            $display("FAIL bad_dest_pulses: err=%0d valid=%0d, expected err=1 valid=0", n_err - e0, n_valid - v0);
        end
        checks++;
        if (cmd_id !== 8'h02) begin
            errors++;
            $display("FAIL bad_dest_hold: cmd_id=%h, expected 02", cmd_id);
        end
    endtask

`ifdef SIPO_CHECKSUM_EN
    task automatic test_bad_checksum();
        int v0, e0;
        v0 = n_valid;
        e0 = n_err;
        push_frame(8'h41, 32'h44332211, 0, 1'b1, 8'hFF);
        run_stream();
        wait_drain(50);
        checks++;
        if (n_err !== e0 + 1 || n_valid !== v0) begin
            errors++;
            $display("FAIL bad_chk_pulses: err=%0d valid=%0d, expected err=1 valid=0", n_err - e0, n_valid - v0);
        end
        checks++;
        if (cmd_id !== 8'h02) begin
            errors++;
            $display("FAIL bad_chk_hold: cmd_id=%h, expected 02", cmd_id);
        end
    endtask
`endif

    task automatic test_abort();
        int          d0;
        logic [31:0] d;
        d0 = n_done;
        push_byte(HDR, 0);
        push_byte(8'h41, 0);
        push_byte(8'h11, 0);
        run_stream();
        sipo_en = 1'b0;
        mdl_buf.delete();
        repeat (3) @(negedge clk);
        sipo_en = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (n_done !== d0) begin
            errors++;
            $display("FAIL abort_done: %0d sipo_done pulses after abort, expected 0", n_done - d0);
        end
        d = $urandom;
        push_frame(8'h80, d, 0, 1'b0, 8'h00);
        run_stream();
        wait_drain(50);
        checks++;
        if (cmd_id !== 8'h80 || cmd_data !== d || cmd_dest !== 2'b10) begin
            errors++;
            $display("FAIL abort_next: id=%h data=%h dest=%b, expected 80 %h 10", cmd_id, cmd_data, cmd_dest, d);
        end
    endtask

    task automatic test_bubbles_inflight();
        int          v0;
        logic [31:0] d1, d2;
        v0 = n_valid;
        d1 = $urandom;
        d2 = $urandom;
        push_frame(8'h4A, d1, 1, 1'b0, 8'h00);
        push_frame(8'h13, d2, 0, 1'b0, 8'h00);
        run_stream();
        wait_drain(80);
        checks++;
        if (n_valid !== v0 + 2) begin
            errors++;
            $display("FAIL inflight_valid: %0d valid pulses, expected 2", n_valid - v0);
        end
        checks++;
        if (cmd_id !== 8'h13 || cmd_data !== d2 || cmd_dest !== 2'b00) begin
            errors++;
            $display("FAIL inflight_fields: id=%h data=%h dest=%b, expected 13 %h 00", cmd_id, cmd_data, cmd_dest, d2);
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [31:0] d;
        push_byte(HDR, 0);
        push_byte(8'h01, 0);
        push_byte(8'h55, 0);
        run_stream();
        rst = 1'b1;
        mdl_buf.delete();
        mdl_id   = '0;
        mdl_data = '0;
        mdl_dest = '0;
        @(negedge clk);
        checks++;
        if ({sipo_done, frame_valid, frame_err} !== 3'b000 || {cmd_id, cmd_data, cmd_dest} !== 42'd0) begin
            errors++;
            $display("FAIL mid_reset: pulses=%b id=%h data=%h dest=%b, expected all zero",
                     {sipo_done, frame_valid, frame_err}, cmd_id, cmd_data, cmd_dest);
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);
        d = $urandom;
        push_frame(8'h42, d, 0, 1'b0, 8'h00);
        run_stream();
        wait_drain(50);
        checks++;
        if (cmd_id !== 8'h42 || cmd_data !== d || cmd_dest !== 2'b01) begin
            errors++;
            $display("FAIL post_reset_frame: id=%h data=%h dest=%b, expected 42 %h 01", cmd_id, cmd_data, cmd_dest, d);
        end
    endtask

    task automatic test_random();
        int         d0, x0;
        logic [7:0] junk;
        d0 = n_done;
        x0 = n_exp;
        for (int f = 0; f < 40; f++) begin
            for (int j = 0; j < $urandom_range(0, 2); j++) begin
                junk = 8'($urandom);
                if (junk == HDR) junk = 8'h00;
                push_byte(junk, $urandom_range(0, 2));
            end
            push_frame(8'($urandom), $urandom, $urandom_range(0, 2),
                       ($urandom_range(0, 4) == 0), 8'($urandom));
        end
        run_stream();
        wait_drain(200);
        checks++;
        if (n_done - d0 !== n_exp - x0) begin
            errors++;
            $display("FAIL random_count: %0d frames terminated, expected %0d", n_done - d0, n_exp - x0);
        end
    endtask

    initial begin
        rst     = 1'b1;
        sipo_en = 1'b0;
        rd_en   = 1'b0;
        empty   = 1'b1;
        din     = '0;
        test_reset();
        test_basic();
        test_hunt();
        test_bad_dest();
`ifdef SIPO_CHECKSUM_EN
        test_bad_checksum();
`endif
        test_abort();
        test_bubbles_inflight();
        test_reset_mid_frame();
        test_random();
        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
